alu_sched: RTL and testbench

- Round-robin scheduler that shares one 16-bit combinational ALU (mode/select/in_a/in_b/carry_in → alu_out/carry_out/compare) between NUM_REQ requesters.
- Accepts one operation at a time over per-requester valid/ready and drives the ALU from registered operands.
- Captures the ALU outputs and returns them, tagged with the requester ID, over a single valid/ready response channel.
- Sits between the register-file/sequencer clients and the shared ALU instance.

---
 rtl/alu_sched_pkg.sv | 31 +++
 rtl/alu_sched_rr_arbiter.sv | 40 ++++
 rtl/alu_sched.sv | 195 +++++++++++++++++++
 tb/tb_alu_sched.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_sched_pkg: shared types and ALU encodings for the ALU scheduler.
// Rev 1.0
// ------------------------------------------------------------------
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic ALU_MODE_LOGIC = 1'b0;
  localparam logic ALU_MODE_ARITH = 1'b1;

  localparam logic [3:0] SEL_ADD = 4'b1001;
  localparam logic [3:0] SEL_SUB = 4'b0110;

  localparam int ALU_W = 16;

  typedef struct packed {
    logic             mode;
    logic [3:0]       select;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             carry;
  } op_t;

endpackage
`default_nettype wire

// File: rtl/alu_sched_rr_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick starting at ptr_i.
// Rev 1.0
// ------------------------------------------------------------------
module rr_arbiter
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  // One extra bit so ptr + offset can exceed NUM_REQ before wrapping.
  logic [ID_W:0] slot;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    slot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = {1'b0, ptr_i} + (ID_W+1)'(i);
      if (slot >= (ID_W+1)'(NUM_REQ))
        slot = slot - (ID_W+1)'(NUM_REQ);
      if (!any_o && req_i[slot[ID_W-1:0]]) begin
        any_o                  = 1'b1;
        gnt_o[slot[ID_W-1:0]]  = 1'b1;
        idx_o                  = slot[ID_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_sched: round-robin scheduler sharing one ALU among NUM_REQ clients.
// Rev 1.0 -- multi-word carry chaining enabled by ALU_SCHED_CHAIN_EN.
// ------------------------------------------------------------------
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_mode,
  input  logic [NUM_REQ*4-1:0]      req_select,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_carry,
`ifdef ALU_SCHED_CHAIN_EN
  input  logic [NUM_REQ-1:0]        req_chain,
`endif
  output logic                      alu_mode,
  output logic [3:0]                alu_select,
  output logic [DATA_W-1:0]         alu_in_a,
  output logic [DATA_W-1:0]         alu_in_b,
  output logic                      alu_carry_in,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_carry_out,
  input  logic                      alu_compare,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_carry,
  output logic                      rsp_compare
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic               accept;
  logic               lock_hold;
  op_t                op_q, op_sel;

  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_carry_q;
  logic               rsp_compare_q;

`ifdef ALU_SCHED_CHAIN_EN
  logic               lock_q;
  logic [ID_W-1:0]    lock_id_q;
  logic               saved_carry_q;
  logic               chain_q;
  logic [NUM_REQ-1:0] lock_mask;

  // While a chain is open only its owner may be granted.
  always_comb begin
    lock_mask            = '0;
    lock_mask[lock_id_q] = 1'b1;
    elig                 = lock_q ? (req_valid & lock_mask) : req_valid;
  end

  assign lock_hold = lock_q;
`else
  assign elig      = req_valid;
  assign lock_hold = 1'b0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign accept = (state_q == IDLE) && gnt_any;

  always_comb begin
    op_sel.mode   = req_mode[gnt_idx];
    op_sel.select = req_select[gnt_idx*4 +: 4];
    op_sel.a      = req_a[gnt_idx*DATA_W +: DATA_W];
    op_sel.b      = req_b[gnt_idx*DATA_W +: DATA_W];
`ifdef ALU_SCHED_CHAIN_EN
    op_sel.carry  = lock_q ? saved_carry_q : req_carry[gnt_idx];
`else
    op_sel.carry  = req_carry[gnt_idx];
`endif
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && !lock_hold)
      rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is visible only in IDLE and never while reset is applied.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst)
      req_ready = gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      op_q          <= '0;
      id_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_carry_q   <= 1'b0;
      rsp_compare_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        op_q <= op_sel;
        id_q <= gnt_idx;
      end
      if (state_q == EXEC) begin
        rsp_valid_q   <= 1'b1;
        rsp_id_q      <= id_q;
        rsp_data_q    <= alu_result;
        rsp_carry_q   <= alu_carry_out;
        rsp_compare_q <= alu_compare;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_SCHED_CHAIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q        <= 1'b0;
      lock_id_q     <= '0;
      saved_carry_q <= 1'b0;
      chain_q       <= 1'b0;
    end else begin
      if (accept)
        chain_q <= req_chain[gnt_idx];
      // The lock follows the chain bit of the op that just executed.
      if (state_q == EXEC) begin
        lock_q    <= chain_q;
        lock_id_q <= id_q;
        if (chain_q)
          saved_carry_q <= alu_carry_out;
      end
    end
  end
`endif

  assign alu_mode     = op_q.mode;
  assign alu_select   = op_q.select;
  assign alu_in_a     = op_q.a;
  assign alu_in_b     = op_q.b;
  assign alu_carry_in = op_q.carry;

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_compare  = rsp_compare_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_alu_sched: directed vectors, multi-cycle sequences and random
// traffic against a cycle-level reference model of the scheduler.
// Rev 1.0
// ------------------------------------------------------------------
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_mode;
  logic [N*4-1:0]  req_select;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N-1:0]    req_carry;
`ifdef ALU_SCHED_CHAIN_EN
  logic [N-1:0]    req_chain;
`endif
  logic            alu_mode;
  logic [3:0]      alu_select;
  logic [W-1:0]    alu_in_a;
  logic [W-1:0]    alu_in_b;
  logic            alu_carry_in;
  logic [W-1:0]    alu_result;
  logic            alu_carry_out;
  logic            alu_compare;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_data;
  logic            rsp_carry;
  logic            rsp_compare;

  op_t ops [N];
  int  n_checks = 0;
  int  n_pass   = 0;

  always #5 clk = ~clk;

  alu_sched #(.NUM_REQ(N), .DATA_W(W), .ID_W(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_mode      (req_mode),
    .req_select    (req_select),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_carry     (req_carry),
`ifdef ALU_SCHED_CHAIN_EN
    .req_chain     (req_chain),
`endif
    .alu_mode      (alu_mode),
    .alu_select    (alu_select),
    .alu_in_a      (alu_in_a),
    .alu_in_b      (alu_in_b),
    .alu_carry_in  (alu_carry_in),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out),
    .alu_compare   (alu_compare),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_carry     (rsp_carry),
    .rsp_compare   (rsp_compare)
  );

  always_comb begin
    req_mode   = '0;
    req_select = '0;
    req_a      = '0;
    req_b      = '0;
    req_carry  = '0;
    for (int i = 0; i < N; i++) begin
      req_mode[i]          = ops[i].mode;
      req_select[i*4 +: 4] = ops[i].select;
      req_a[i*W +: W]      = ops[i].a;
      req_b[i*W +: W]      = ops[i].b;
      req_carry[i]         = ops[i].carry;
    end
  end

  // Stand-in for the shared ALU: {carry_out, result}; asymmetric in a/b.
  function automatic logic [16:0] alu_fn(input logic m, input logic [3:0] s,
                                         input logic [15:0] a, input logic [15:0] b,
                                         input logic c);
    if (m == ALU_MODE_ARITH) begin
      if (s == SEL_ADD) return {1'b0, a} + {1'b0, b} + {16'h0, c};
      if (s == SEL_SUB) return {1'b0, a} + {1'b0, ~b} + {16'h0, c};
      return {c, a ^ {b[14:0], b[15]} ^ {12'h0, s}};
    end
    return {c, (a & ~b) | {12'h0, s}};
  endfunction

  assign {alu_carry_out, alu_result} = alu_fn(alu_mode, alu_select, alu_in_a, alu_in_b, alu_carry_in);
  assign alu_compare = (alu_in_a == alu_in_b);

  function automatic op_t mk(input logic m, input logic [3:0] s, input logic [15:0] a,
                             input logic [15:0] b, input logic c);
    op_t o;
    o.mode = m; o.select = s; o.a = a; o.b = b; o.carry = c;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.mode = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 2))
      0:       o.select = SEL_ADD;
      1:       o.select = SEL_SUB;
      default: o.select = 4'($urandom_range(0, 15));
    endcase
    o.a     = 16'($urandom);
    o.b     = ($urandom_range(0, 3) == 0) ? o.a : 16'($urandom);
    o.carry = 1'($urandom_range(0, 1));
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_a"},   32'(alu_in_a), 0);
    check({tag, "_alu_b"},   32'(alu_in_b), 0);
    check({tag, "_alu_ctl"}, 32'({alu_mode, alu_select, alu_carry_in}), 0);
    check({tag, "_rsp_vld"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_id"},  32'(rsp_id), 0);
    check({tag, "_rsp_dat"}, 32'(rsp_data), 0);
    check({tag, "_rsp_flg"}, 32'({rsp_carry, rsp_compare}), 0);
    check({tag, "_ready"},   32'(req_ready), 0);
  endtask

  // Entered at a negedge with inputs already driven; leaves at negedge+1 with the grant visible.
  task automatic wait_grant(input int id, input string name);
    bit seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      #1;
      if (req_ready[id]) seen = 1'b1;
      else @(negedge clk);
    end
    check(name, 32'(seen), 1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
`ifdef ALU_SCHED_CHAIN_EN
    req_chain = '0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Cycle-level reference: phase 0 waiting, 1 executing, 2 responding.
  task automatic run_model(input int ncyc, input bit all_mode);
    int           ph = 0;
    int           ptr = 0;
    int           g;
    int           rcount = 0;
    int           cur_id = 0;
    op_t          cur = '0;
    logic [16:0]  exp_res = '0;
    logic         exp_cmp = 1'b0;
    logic [N-1:0] mv = '0;
    logic [N-1:0] exp_rdy;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < N; i++)
        if (!mv[i] && (all_mode || $urandom_range(0, 2) == 0)) begin
          mv[i]  = 1'b1;
          ops[i] = rand_op();
        end
      req_valid = mv;
      rsp_ready = all_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      if (ph == 0)
        for (int k = 0; k < N; k++)
          if (g < 0 && mv[(ptr + k) % N]) g = (ptr + k) % N;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("m_ready", 32'(req_ready), 32'(exp_rdy));
      check("m_rsp_valid", 32'(rsp_valid), 32'(ph == 2));
      check("m_alu_a", 32'(alu_in_a), 32'(cur.a));
      check("m_alu_b", 32'(alu_in_b), 32'(cur.b));
      check("m_alu_ctl", 32'({alu_mode, alu_select, alu_carry_in}),
            32'({cur.mode, cur.select, cur.carry}));
      if (ph == 2) begin
        check("m_rsp_id", 32'(rsp_id), 32'(cur_id));
        check("m_rsp_data", 32'(rsp_data), 32'(exp_res[15:0]));
        check("m_rsp_flags", 32'({rsp_carry, rsp_compare}), 32'({exp_res[16], exp_cmp}));
        if (all_mode) check("rr_order", 32'(rsp_id), 32'(rcount % N));
      end
      case (ph)
        0: if (g >= 0) begin
             cur    = ops[g];
             cur_id = g;
             ptr    = (g + 1) % N;
             mv[g]  = 1'b0;
             ph     = 1;
           end
        1: begin
             exp_res = alu_fn(cur.mode, cur.select, cur.a, cur.b, cur.carry);
             exp_cmp = (cur.a == cur.b);
             ph      = 2;
           end
        default: if (rsp_ready) begin
             rcount++;
             ph = 0;
           end
      endcase
      @(negedge clk);
    end
  endtask

  typedef struct {
    int          id;
    op_t         op;
    logic [15:0] e_data;
    logic        e_carry;
    logic        e_cmp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{0, mk(1'b1, SEL_ADD, 16'h0003, 16'h0004, 1'b0), 16'h0007, 1'b0, 1'b0};
    vecs[1] = '{1, mk(1'b1, SEL_ADD, 16'hFFFF, 16'h0001, 1'b0), 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{2, mk(1'b1, SEL_SUB, 16'h0005, 16'h0003, 1'b1), 16'h0002, 1'b1, 1'b0};
    vecs[3] = '{3, mk(1'b1, SEL_ADD, 16'hBEEF, 16'hBEEF, 1'b0), 16'h7DDE, 1'b1, 1'b1};
    vecs[4] = '{0, mk(1'b0, 4'h3,    16'hBEEF, 16'h1234, 1'b1), 16'hACCB, 1'b1, 1'b0};
    vecs[5] = '{2, mk(1'b0, 4'h0,    16'h1234, 16'h1234, 1'b0), 16'h0000, 1'b0, 1'b1};
    vecs[6] = '{1, mk(1'b1, SEL_SUB, 16'hBEEF, 16'hBEEF, 1'b1), 16'h0000, 1'b1, 1'b1};

    for (int i = 0; i < N; i++) ops[i] = '0;
    req_valid = '1;
    rsp_ready = 1'b0;
`ifdef ALU_SCHED_CHAIN_EN
    req_chain = '0;
`endif
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("reset");
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed single-op vectors: grant, 1-cycle alu_* latency, 2-cycle response latency.
    rsp_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      ops[vecs[v].id] = vecs[v].op;
      req_valid = '0;
      req_valid[vecs[v].id] = 1'b1;
      wait_grant(vecs[v].id, "vec_grant");
      check("vec_ready", 32'(req_ready), 32'(1) << vecs[v].id);
      @(negedge clk);
      req_valid = '0;
      #1;
      check("vec_alu_a", 32'(alu_in_a), 32'(vecs[v].op.a));
      check("vec_alu_b", 32'(alu_in_b), 32'(vecs[v].op.b));
      check("vec_alu_ctl", 32'({alu_mode, alu_select, alu_carry_in}),
            32'({vecs[v].op.mode, vecs[v].op.select, vecs[v].op.carry}));
      check("vec_early_rsp", 32'(rsp_valid), 0);
      @(negedge clk);
      #1;
      check("vec_rsp_valid", 32'(rsp_valid), 1);
      check("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
      check("vec_rsp_data", 32'(rsp_data), 32'(vecs[v].e_data));
      check("vec_rsp_carry", 32'(rsp_carry), 32'(vecs[v].e_carry));
      check("vec_rsp_cmp", 32'(rsp_compare), 32'(vecs[v].e_cmp));
      @(negedge clk);
      #1;
      check("vec_rsp_drop", 32'(rsp_valid), 0);
    end

    // Backpressure: response held for several cycles, no grant until it is taken.
    do_reset();
    ops[2] = mk(1'b1, SEL_ADD, 16'h1000, 16'h0234, 1'b1);
    req_valid = 4'b0100;
    wait_grant(2, "bp_grant");
    @(negedge clk);
    ops[0] = mk(1'b1, SEL_ADD, 16'h0A0A, 16'h0505, 1'b1);
    req_valid = 4'b0101;
    #1;
    check("bp_exec_ready", 32'(req_ready), 0);
    @(negedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", 32'(rsp_valid), 1);
      check("bp_hold_id", 32'(rsp_id), 2);
      check("bp_hold_data", 32'(rsp_data), 32'h1235);
      check("bp_hold_ready", 32'(req_ready), 0);
      @(negedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    check("bp_release_ready", 32'(req_ready), 0);
    check("bp_release_valid", 32'(rsp_valid), 1);
    @(negedge clk);
    #1;
    check("bp_after_valid", 32'(rsp_valid), 0);
    check("bp_next_grant", 32'(req_ready), 32'h1);

    // Reset during EXEC of req0: everything clears at once, op is dropped.
    @(negedge clk);
    req_valid = '0;
    #1;
    check("rx_exec_a", 32'(alu_in_a), 32'h0A0A);
    rst = 1'b1;
    #1;
    check_all_zero("rst_exec");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check("rx_no_rsp", 32'(rsp_valid), 0);
    end
    req_valid = 4'b1001;
    #1;
    check("rx_ptr_zero", 32'(req_ready), 32'h1);

    // All requesters continuously valid from reset: strict 0,1,2,3 rotation.
    do_reset();
    run_model(40, 1'b1);

    // Random traffic with random backpressure.
    do_reset();
    run_model(600, 1'b0);

`ifdef ALU_SCHED_CHAIN_EN
    // Chain: req1 low word locks the ALU; its high word gets the saved carry ahead of req0.
    do_reset();
    rsp_ready = 1'b1;
    ops[1]    = mk(1'b1, SEL_ADD, 16'hFFFF, 16'h0001, 1'b0);
    req_chain = 4'b0010;
    req_valid = 4'b0010;
    wait_grant(1, "ch_grant_lo");
    @(negedge clk);
    ops[0]    = mk(1'b1, SEL_ADD, 16'h0005, 16'h0006, 1'b0);
    ops[1]    = mk(1'b1, SEL_ADD, 16'h0000, 16'h0000, 1'b0);
    req_chain = 4'b0000;
    req_valid = 4'b0011;
    #1;
    check("ch_exec_ready", 32'(req_ready), 0);
    @(negedge clk);
    #1;
    check("ch_lo_data", 32'(rsp_data), 32'h0000);
    check("ch_lo_carry", 32'(rsp_carry), 1);
    @(negedge clk);
    #1;
    check("ch_locked_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    check("ch_carry_in", 32'(alu_carry_in), 1);
    @(negedge clk);
    #1;
    check("ch_hi_id", 32'(rsp_id), 1);
    check("ch_hi_data", 32'(rsp_data), 32'h0001);
    @(negedge clk);
    #1;
    check("ch_unlock_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
